bcd_opg_serial_tx: RTL and testbench
====================================

// Module: bcd_opg_serial_tx
// PURPOSE
//  Serial transmitter for the BCD odd-parity link. Accepts one parallel BCD digit
//  per valid/ready handshake and shifts out a 5-bit frame: 4 data bits, then 1 odd-parity bit.
//  Drives the x input of the downstream serial BCD parity FSM, one bit per clock.
//  Rejects non-BCD codes (10..15) without emitting a frame.
// PARAMETERS
//  LSB_FIRST   1  1: data bits sent d[0]..d[3]; 0: sent d[3]..d[0]
//  GAP_CYCLES  0  idle cycles forced after each parity bit (0..15); 0 = back-to-back frames
// PORTS
//  clock       in   1  rising-edge clock
//  reset       in   1  asynchronous, active-low reset
//  din_valid   in   1  din_digit is offered this cycle
//  din_digit   in   4  BCD digit to send
//  din_ready   out  1  block accepts din_digit this cycle
//  sx          out  1  serial bit (0 when sx_valid=0)
//  sx_valid    out  1  sx carries a frame bit this cycle
//  sx_first    out  1  high on the first data bit of a frame
//  sx_last     out  1  high on the parity bit
//  bad_digit   out  1  one-cycle pulse: offered digit was >9 and was dropped
//  busy        out  1  state is not IDLE
// BEHAVIOUR
//  Reset (async, any time): state=IDLE; shift reg, parity, gap counter = 0;
//   sx/sx_valid/sx_first/sx_last/bad_digit/busy = 0. A partial frame is abandoned, with no resume.
//  States: IDLE, D0, D1, D2, D3, PAR, GAP. Outputs are decoded from the state and registers.
//  din_ready = (state==IDLE) | (state==PAR & GAP_CYCLES==0). Accept = din_valid & din_ready.
//  On accept with digit<=9: latch digit into shift reg; parity <= ~^digit
//   (total ones over 5 bits is odd). Next state = D0.
//  Latency: the accepting edge is followed by the first data bit in the next cycle.
//   The frame occupies exactly 5 consecutive cycles.
//  D0..D3: sx = current data bit (order per LSB_FIRST), sx_valid=1. sx_first=1 only in D0.
//  PAR: sx = parity, sx_valid=1, sx_last=1. Next state:
//   GAP (counter loaded with GAP_CYCLES-1) if GAP_CYCLES>0;
//   else D0 if a valid digit is accepted; else IDLE.
//  GAP: sx_valid=0, din_ready=0. Count down; go to IDLE after GAP_CYCLES cycles.
//  Accept with digit>9: the handshake completes (digit consumed), bad_digit=1 in the next cycle.
//   No frame starts; the state goes to (or stays in) IDLE.
//   If this happens in PAR, the parity bit still completes normally.
//  din_digit changes after accept are ignored; the latched copy is sent.
//  din_valid while din_ready=0: there is no effect. The source must hold the digit until ready.
//  busy = 1 in D0..D3, PAR and GAP.
// STRUCTURE
//  Shared header bcd_opg_defs.vh: state encodings (3-bit), FRAME_BITS=5, BCD_MAX=4'd9,
//   and the parity function, also used by the receiving FSM and its bench.
//  Single module with no sub-modules: state register, 4-bit shift reg, parity flop, 4-bit gap counter.
// TESTING
//  digit=5 (0101), LSB_FIRST=1 -> sx = 1,0,1,0 then parity 1; sx_first on bit 1, sx_last on bit 5.
//  digit=7 (0111) -> sx = 1,1,1,0, parity 0. digit=0 -> 0,0,0,0, parity 1. LSB_FIRST=0, digit=8 -> 1,0,0,0, parity 0.
//  digit=12 offered in IDLE -> din_ready=1, bad_digit pulses 1 cycle later, sx_valid remains 0, busy remains 0.
//  GAP=0, digits 3 then 9 held valid -> 10 consecutive sx_valid cycles: 1,1,0,0,1 | 1,0,0,1,1.
//  GAP_CYCLES=2 -> after sx_last, din_ready=0 and sx_valid=0 for 2 cycles, then din_ready=1.
//  reset low during D2 -> all outputs 0 immediately. After release: IDLE, din_ready=1, next digit sends a full clean frame.

Source files
------------

// File: rtl/bcd_opg_serial_tx_pkg.sv
// bcd_opg_serial_tx_pkg: shared state encoding, constants and parity helper
package bcd_opg_serial_tx_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D0   = 3'd1,
        D1   = 3'd2,
        D2   = 3'd3,
        D3   = 3'd4,
        PAR  = 3'd5,
        GAP  = 3'd6
    } state_e;
    localparam int FRAME_BITS = 5;
    localparam logic [3:0] BCD_MAX = 4'd9;
    function automatic logic odd_par(input logic [3:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/bcd_opg_serial_tx.sv
// bcd_opg_serial_tx: BCD digit to 5-bit odd-parity serial frame transmitter
module bcd_opg_serial_tx
    import bcd_opg_serial_tx_pkg::*;
#(
    parameter bit LSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       din_valid,
    input  logic [3:0] din_digit,
    output logic       din_ready,
    output logic       sx,
    output logic       sx_valid,
    output logic       sx_first,
    output logic       sx_last,
    output logic       bad_digit,
    output logic       busy
);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    state_e     state_q, state_d;
    logic [3:0] shift_q, gap_q;
    logic       par_q, bad_q;
    logic       accept, good, data_st;
    assign accept  = din_valid & din_ready;
    assign good    = accept & (din_digit <= BCD_MAX);
    assign data_st = (state_q == D0) | (state_q == D1) | (state_q == D2) | (state_q == D3);
    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end
    // next-state logic; a rejected digit leaves the machine heading to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = good ? D0 : IDLE;
            D0:      state_d = D1;
            D1:      state_d = D2;
            D2:      state_d = D3;
            D3:      state_d = PAR;
            PAR:     state_d = (GAP_CYCLES > 0) ? GAP : (good ? D0 : IDLE);
            GAP:     state_d = (gap_q == 4'd0) ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end
    // datapath: latch accepted digit, shift one bit per data cycle, count gap, flag rejects
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= 4'd0;
            par_q   <= 1'b0;
            gap_q   <= 4'd0;
            bad_q   <= 1'b0;
        end else begin
            if (good) begin
                shift_q <= din_digit;
                par_q   <= odd_par(din_digit);
            end else if (data_st) begin
                shift_q <= LSB_FIRST ? {1'b0, shift_q[3:1]} : {shift_q[2:0], 1'b0};
            end
            if (state_q == PAR && GAP_CYCLES > 0) gap_q <= GAP_LOAD;
            else if (state_q == GAP && gap_q != 4'd0) gap_q <= gap_q - 4'd1;
            bad_q <= accept & (din_digit > BCD_MAX);
        end
    end
    // outputs decoded from state and registers
    always_comb begin
        din_ready = (state_q == IDLE) | ((state_q == PAR) & (GAP_CYCLES == 0));
        sx_valid  = data_st | (state_q == PAR);
        sx        = (state_q == PAR) ? par_q : (data_st ? (LSB_FIRST ? shift_q[0] : shift_q[3]) : 1'b0);
        sx_first  = (state_q == D0);
        sx_last   = (state_q == PAR);
        bad_digit = bad_q;
        busy      = (state_q != IDLE);
    end
endmodule

// File: tb/tb_bcd_opg_serial_tx.sv
// tb_bcd_opg_serial_tx: directed and random checks of three transmitter configurations
module tb_bcd_opg_serial_tx;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       v[3];
    logic [3:0] d[3];
    logic       rdy[3], sx[3], sxv[3], sxf[3], sxl[3], bad[3], busy[3];
    int         errors = 0;
    int         checks = 0;

    always #5 clock = ~clock;

    // 0: LSB first, no gap; 1: MSB first, no gap; 2: LSB first, 2-cycle gap
    bcd_opg_serial_tx #(.LSB_FIRST(1'b1), .GAP_CYCLES(0)) dut (
        .clock(clock), .reset(reset), .din_valid(v[0]), .din_digit(d[0]), .din_ready(rdy[0]),
        .sx(sx[0]), .sx_valid(sxv[0]), .sx_first(sxf[0]), .sx_last(sxl[0]), .bad_digit(bad[0]), .busy(busy[0]));
    bcd_opg_serial_tx #(.LSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_m (
        .clock(clock), .reset(reset), .din_valid(v[1]), .din_digit(d[1]), .din_ready(rdy[1]),
        .sx(sx[1]), .sx_valid(sxv[1]), .sx_first(sxf[1]), .sx_last(sxl[1]), .bad_digit(bad[1]), .busy(busy[1]));
    bcd_opg_serial_tx #(.LSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_g (
        .clock(clock), .reset(reset), .din_valid(v[2]), .din_digit(d[2]), .din_ready(rdy[2]),
        .sx(sx[2]), .sx_valid(sxv[2]), .sx_first(sxf[2]), .sx_last(sxl[2]), .bad_digit(bad[2]), .busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: frame bit i of a digit, computed from the frame definition
    function automatic logic ref_bit(input int digit, input bit lsb, input int i);
        if (i < 4) return ((digit >> (lsb ? i : 3 - i)) & 1) != 0;
        return ($countones(digit[3:0]) % 2) == 0;
    endfunction

    function automatic bit lsb_of(input int k);
        return k != 1;
    endfunction

    task automatic wait_ready(input int k);
        int n = 0;
        while (!rdy[k] && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("ready_wait%0d", k), rdy[k], 1'b1);
    endtask

    // offer a valid digit, then check all five frame bits against the reference
    task automatic send(input int k, input int digit);
        @(negedge clock);
        v[k] = 1'b1;
        d[k] = 4'(digit);
        wait_ready(k);
        @(negedge clock);
        v[k] = 1'b0;
        d[k] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("sxv%0d_%0d_b%0d", k, digit, i), sxv[k], 1'b1);
            chk($sformatf("sx%0d_%0d_b%0d", k, digit, i), sx[k], ref_bit(digit, lsb_of(k), i));
            chk($sformatf("first%0d_b%0d", k, i), sxf[k], i == 0);
            chk($sformatf("last%0d_b%0d", k, i), sxl[k], i == 4);
            @(negedge clock);
        end
    endtask

    // offer a non-BCD digit while idle: consumed, flagged, no frame
    task automatic send_bad(input int k, input int digit);
        @(negedge clock);
        v[k] = 1'b1;
        d[k] = 4'(digit);
        wait_ready(k);
        @(negedge clock);
        v[k] = 1'b0;
        chk($sformatf("bad%0d_%0d", k, digit), bad[k], 1'b1);
        chk($sformatf("bad_sxv%0d", k), sxv[k], 1'b0);
        chk($sformatf("bad_busy%0d", k), busy[k], 1'b0);
        @(negedge clock);
        chk($sformatf("bad_pulse%0d", k), bad[k], 1'b0);
        chk($sformatf("bad_sxv2_%0d", k), sxv[k], 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0;
            d[k] = 4'd0;
        end
        // reset state
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            chk("rst_sxv", sxv[k], 1'b0);
            chk("rst_sx", sx[k], 1'b0);
            chk("rst_busy", busy[k], 1'b0);
            chk("rst_bad", bad[k], 1'b0);
            chk("rst_ready", rdy[k], 1'b1);
        end
        @(negedge clock);
        reset = 1'b1;
        // directed frames
        send(0, 5);
        send(0, 7);
        send(0, 0);
        send(1, 8);
        send_bad(0, 12);
        // back-to-back 3 then 9 with valid held
        @(negedge clock);
        v[0] = 1'b1;
        d[0] = 4'd3;
        @(negedge clock);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("b2b_sxv%0d", c), sxv[0], 1'b1);
            chk($sformatf("b2b_sx%0d", c), sx[0], ref_bit(c < 5 ? 3 : 9, 1'b1, c % 5));
            if (c == 0) d[0] = 4'd9;
            if (c == 5) v[0] = 1'b0;
            @(negedge clock);
        end
        chk("b2b_idle", sxv[0], 1'b0);
        // non-BCD digit offered during parity: parity finishes, then IDLE with flag
        @(negedge clock);
        v[0] = 1'b1;
        d[0] = 4'd6;
        @(negedge clock);
        v[0] = 1'b0;
        repeat (4) @(negedge clock);
        v[0] = 1'b1;
        d[0] = 4'd13;
        chk("parbad_last", sxl[0], 1'b1);
        chk("parbad_sx", sx[0], ref_bit(6, 1'b1, 4));
        chk("parbad_ready", rdy[0], 1'b1);
        @(negedge clock);
        v[0] = 1'b0;
        chk("parbad_flag", bad[0], 1'b1);
        chk("parbad_sxv", sxv[0], 1'b0);
        chk("parbad_busy", busy[0], 1'b0);
        // gap of two idle cycles after parity
        send(2, 4);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("gap_ready%0d", g), rdy[2], 1'b0);
            chk($sformatf("gap_sxv%0d", g), sxv[2], 1'b0);
            chk($sformatf("gap_busy%0d", g), busy[2], 1'b1);
            @(negedge clock);
        end
        chk("gap_done_ready", rdy[2], 1'b1);
        chk("gap_done_busy", busy[2], 1'b0);
        // asynchronous reset in the middle of a frame
        @(negedge clock);
        v[0] = 1'b1;
        d[0] = 4'd5;
        @(negedge clock);
        v[0] = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre_rst_busy", busy[0], 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_sxv", sxv[0], 1'b0);
        chk("midrst_sx", sx[0], 1'b0);
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_first", sxf[0], 1'b0);
        chk("midrst_last", sxl[0], 1'b0);
        chk("midrst_ready", rdy[0], 1'b1);
        @(negedge clock);
        reset = 1'b1;
        send(0, 2);
        // random traffic against the reference model
        for (int r = 0; r < 40; r++) begin
            int k = $urandom_range(0, 2);
            int dg = $urandom_range(0, 15);
            if (dg <= 9) send(k, dg);
            else send_bad(k, dg);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
